// File: rtl/bcd_counter_display_if.sv
// Board-facing signal bundle for bcd_counter_display: switches/buttons in,
// LED count and active-low seven-segment bytes out.
interface bcd_counter_display_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic [WIDTH-1:0]    data_input;
   logic                ctrl_load;
   logic                ctrl_inc;
   logic                ctrl_dec;
   logic [WIDTH-1:0]    data_output_led;
   logic [8*DIGITS-1:0] data_output_sevensegs;
   logic                conv_busy;

   modport master (
      output data_input, ctrl_load, ctrl_inc, ctrl_dec,
      input  data_output_led, data_output_sevensegs, conv_busy
   );

   modport slave (
      input  data_input, ctrl_load, ctrl_inc, ctrl_dec,
      output data_output_led, data_output_sevensegs, conv_busy
   );
endinterface

// File: rtl/bcd_counter_display.sv
// Debounced up/down counter with parallel load, driving LEDs and a sequential
// double-dabble seven-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
//
// state    | meaning
// S_IDLE   | waiting for count to differ from last converted value
// S_CONV   | one add-3/shift double-dabble step per clock, WIDTH steps
// S_UPDATE | encode BCD digits into the display register
module bcd_counter_display #(
   parameter int WIDTH           = 8,
   parameter int DIGITS          = 3,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int WRAP            = 1
) (
   input  logic                 clk,
   input  logic                 async_reset,
   bcd_counter_display_if.slave bus
);
   localparam int DBW        = $clog2(DEBOUNCE_CYCLES);
   localparam int DIG_NEED   = (WIDTH * 302 + 999) / 1000 + 1;
   localparam int DIGITS_INT = (DIGITS > DIG_NEED) ? DIGITS : DIG_NEED;
   localparam int BCDW       = 4 * DIGITS_INT;
   localparam int ITW        = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_UPDATE} state_t;

   logic [1:0]           raw_btn;
   logic [1:0]           deb_q;
   logic [1:0]           deb_prev_q;
   logic [DBW-1:0]       db_cnt_q [2];
   logic                 inc_pulse;
   logic                 dec_pulse;
   logic [WIDTH-1:0]     count_q, count_d;
   state_t               state_q;
   logic [WIDTH-1:0]     shift_q;
   logic [BCDW-1:0]      bcd_q, bcd_adj;
   logic [ITW-1:0]       iter_q;
   logic [WIDTH-1:0]     cap_q;
   logic [WIDTH-1:0]     last_q;
   logic [8*DIGITS-1:0]  disp_q, disp_d;
   logic                 busy_q;

   function automatic logic [7:0] seg7(input logic [3:0] nib);
      case (nib)
         4'd0: seg7 = 8'hC0;
         4'd1: seg7 = 8'hF9;
         4'd2: seg7 = 8'hA4;
         4'd3: seg7 = 8'hB0;
         4'd4: seg7 = 8'h99;
         4'd5: seg7 = 8'h92;
         4'd6: seg7 = 8'h82;
         4'd7: seg7 = 8'hF8;
         4'd8: seg7 = 8'h80;
         4'd9: seg7 = 8'h90;
         default: seg7 = 8'hFF;
      endcase
   endfunction

   assign raw_btn   = {bus.ctrl_dec, bus.ctrl_inc};
   assign inc_pulse = deb_q[0] & ~deb_prev_q[0];
   assign dec_pulse = deb_q[1] & ~deb_prev_q[1];

   // Counter runs only while raw disagrees with the debounced level.
   always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
         deb_q      <= '0;
         deb_prev_q <= '0;
         db_cnt_q   <= '{default: '0};
      end else begin
         deb_prev_q <= deb_q;
         for (int b = 0; b < 2; b++) begin
            if (raw_btn[b] != deb_q[b]) begin
               if (db_cnt_q[b] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                  deb_q[b]    <= raw_btn[b];
                  db_cnt_q[b] <= '0;
               end else begin
                  db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
               end
            end else begin
               db_cnt_q[b] <= '0;
            end
         end
      end
   end

   always_comb begin
      count_d = count_q;
      if (bus.ctrl_load) begin
         count_d = bus.data_input;
      end else if (inc_pulse && !dec_pulse) begin
         if (count_q == CNT_MAX) count_d = (WRAP != 0) ? '0 : CNT_MAX;
         else                    count_d = count_q + 1'b1;
      end else if (dec_pulse && !inc_pulse) begin
         if (count_q == '0) count_d = (WRAP != 0) ? CNT_MAX : '0;
         else               count_d = count_q - 1'b1;
      end
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS_INT; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic lz_seen;
   always_comb begin
      lz_seen = 1'b0;
      disp_d  = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (bcd_q[4*i +: 4] != 4'd0) lz_seen = 1'b1;
         if (!lz_seen && i != 0) disp_d[8*i +: 8] = 8'hFF;
         else                    disp_d[8*i +: 8] = seg7(bcd_q[4*i +: 4]);
      end
   end
`else
   always_comb begin
      disp_d = '0;
      for (int i = 0; i < DIGITS; i++) disp_d[8*i +: 8] = seg7(bcd_q[4*i +: 4]);
   end
`endif

   always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
         count_q <= '0;
         state_q <= S_IDLE;
         shift_q <= '0;
         bcd_q   <= '0;
         iter_q  <= '0;
         cap_q   <= '0;
         last_q  <= '0;
         disp_q  <= {DIGITS{8'hC0}};
         busy_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         case (state_q)
            S_IDLE: begin
               if (count_q != last_q) begin
                  cap_q   <= count_q;
                  shift_q <= count_q;
                  bcd_q   <= '0;
                  iter_q  <= '0;
                  state_q <= S_CONV;
                  busy_q  <= 1'b1;
               end
            end
            S_CONV: begin
               bcd_q   <= {bcd_adj[BCDW-2:0], shift_q[WIDTH-1]};
               shift_q <= {shift_q[WIDTH-2:0], 1'b0};
               iter_q  <= iter_q + 1'b1;
               if (iter_q == ITW'(WIDTH - 1)) state_q <= S_UPDATE;
            end
            S_UPDATE: begin
               disp_q  <= disp_d;
               last_q  <= cap_q;
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_output_led       = count_q;
   assign bus.data_output_sevensegs = disp_q;
   assign bus.conv_busy             = busy_q;
endmodule

// File: tb/tb_bcd_counter_display.sv
// Scoreboard bench for bcd_counter_display: a wrapping and a saturating
// instance share stimulus; display updates are checked as conversions finish.
module tb_bcd_counter_display;
   localparam int W  = 8;
   localparam int D  = 3;
   localparam int DB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cnt0 = 0;
   int   cnt1 = 0;
   logic [23:0] sb_q[$];
   logic prev_busy = 1'b0;

   bcd_counter_display_if #(.WIDTH(W), .DIGITS(D)) if0 ();
   bcd_counter_display_if #(.WIDTH(W), .DIGITS(D)) if1 ();

   assign if1.data_input = if0.data_input;
   assign if1.ctrl_load  = if0.ctrl_load;
   assign if1.ctrl_inc   = if0.ctrl_inc;
   assign if1.ctrl_dec   = if0.ctrl_dec;

   bcd_counter_display #(.WIDTH(W), .DIGITS(D), .DEBOUNCE_CYCLES(DB), .WRAP(1)) u_wrap (
      .clk(clk), .async_reset(rst_n), .bus(if0));
   bcd_counter_display #(.WIDTH(W), .DIGITS(D), .DEBOUNCE_CYCLES(DB), .WRAP(0)) u_sat (
      .clk(clk), .async_reset(rst_n), .bus(if1));

   always #5 clk = ~clk;

   function automatic logic [7:0] seg(input int d);
      case (d)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
         4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
         8: return 8'h80;  9: return 8'h90;  default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [23:0] exp_disp(input int v);
      logic [23:0] r;
      r = {seg((v / 100) % 10), seg((v / 10) % 10), seg(v % 10)};
`ifdef LEADING_ZERO_BLANK_EN
      if (v < 100) r[23:16] = 8'hFF;
      if (v < 10)  r[15:8]  = 8'hFF;
`endif
      return r;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   // Monitor: every busy falling edge is a finished conversion.
   always @(negedge clk) begin
      if (prev_busy && !if0.conv_busy) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_update actual %0h required none", if0.data_output_sevensegs);
         end else begin
            check("display", if0.data_output_sevensegs, sb_q.pop_front());
         end
      end
      prev_busy = if0.conv_busy;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input int v);
      if (v != cnt0) sb_q.push_back(exp_disp(v));
      cnt0 = v;
      cnt1 = v;
      if0.data_input = W'(v);
      if0.ctrl_load  = 1'b1;
      step(1);
      if0.ctrl_load  = 1'b0;
      check("load_led_wrap", if0.data_output_led, cnt0);
      check("load_led_sat", if1.data_output_led, cnt1);
      step(20);
   endtask

   task automatic press(input bit inc, input bit dec, input int hold, input bit takes);
      if (takes && (inc ^ dec)) begin
         if (inc) begin
            cnt0 = (cnt0 + 1) % 256;
            cnt1 = (cnt1 == 255) ? 255 : cnt1 + 1;
         end else begin
            cnt0 = (cnt0 + 255) % 256;
            cnt1 = (cnt1 == 0) ? 0 : cnt1 - 1;
         end
         sb_q.push_back(exp_disp(cnt0));
      end
      if0.ctrl_inc = inc;
      if0.ctrl_dec = dec;
      step(hold);
      check("press_led_wrap", if0.data_output_led, cnt0);
      check("press_led_sat", if1.data_output_led, cnt1);
      if0.ctrl_inc = 1'b0;
      if0.ctrl_dec = 1'b0;
      step(20);
      check("release_led_wrap", if0.data_output_led, cnt0);
   endtask

   initial begin
      if0.data_input = '0;
      if0.ctrl_load  = 1'b0;
      if0.ctrl_inc   = 1'b0;
      if0.ctrl_dec   = 1'b0;

      #3 rst_n = 1'b0;
      #1;
      check("reset_led", if0.data_output_led, 0);
      check("reset_segs", if0.data_output_sevensegs, 24'hC0C0C0);
      check("reset_busy", if0.conv_busy, 0);
      step(3);
      rst_n = 1'b1;
      step(3);
      check("idle_after_reset_busy", if0.conv_busy, 0);

      // Load 237 with exact latency checks.
      sb_q.push_back(exp_disp(237));
      cnt0 = 237;
      cnt1 = 237;
      if0.data_input = 8'd237;
      if0.ctrl_load  = 1'b1;
      step(1);
      if0.ctrl_load  = 1'b0;
      check("l237_led", if0.data_output_led, 237);
      step(1);
      check("l237_busy_rise", if0.conv_busy, 1);
      step(W);
      check("l237_disp_old", if0.data_output_sevensegs, 24'hC0C0C0);
      step(1);
      check("l237_disp_new", if0.data_output_sevensegs, 24'hA4B0F8);
      check("l237_busy_fall", if0.conv_busy, 0);
      step(20);

      // Glitch, held presses, repeated presses.
      press(1'b1, 1'b0, 2, 1'b0);
      press(1'b1, 1'b0, 100, 1'b1);
      press(1'b1, 1'b0, 100, 1'b1);
      press(1'b0, 1'b1, 2, 1'b0);
      press(1'b0, 1'b1, 100, 1'b1);
      press(1'b0, 1'b1, 100, 1'b1);

      // Wrap on u_wrap, saturate on u_sat.
      do_load(255);
      press(1'b1, 1'b0, 100, 1'b1);
      do_load(0);
      press(1'b0, 1'b1, 100, 1'b1);

      // Simultaneous inc/dec cancels.
      press(1'b1, 1'b1, 100, 1'b0);

      // Load held across the inc pulse wins.
      sb_q.push_back(exp_disp(42));
      cnt0 = 42;
      cnt1 = 42;
      if0.ctrl_inc = 1'b1;
      step(2);
      if0.data_input = 8'd42;
      if0.ctrl_load  = 1'b1;
      step(6);
      if0.ctrl_load  = 1'b0;
      step(92);
      check("load_beats_inc_wrap", if0.data_output_led, 42);
      check("load_beats_inc_sat", if1.data_output_led, 42);
      if0.ctrl_inc = 1'b0;
      step(20);

      // Count change during a running conversion triggers a second one.
      sb_q.push_back(exp_disp(100));
      sb_q.push_back(exp_disp(101));
      cnt0 = 101;
      cnt1 = 101;
      if0.data_input = 8'd100;
      if0.ctrl_load  = 1'b1;
      step(1);
      if0.ctrl_load  = 1'b0;
      if0.ctrl_inc   = 1'b1;
      step(100);
      check("reconv_led", if0.data_output_led, 101);
      if0.ctrl_inc = 1'b0;
      step(30);

      do_load(7);
      do_load(0);

      for (int i = 0; i < 200 && sb_q.size() != 0; i++) step(1);
      check("scoreboard_drained", sb_q.size(), 0);
      check("final_segs", if0.data_output_sevensegs, exp_disp(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
